// File: rtl/jtpinpon_objline_pkg.sv
// Shared constants for the object line renderer: sprite geometry, FSM encoding
// and the sprite-row pixel extractor.
package jtpinpon_objline_pkg;

    localparam int          OBJ_W  = 16;
    localparam int          BPP    = 2;
    localparam logic [3:0]  TRANSP = 4'd0;

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_FETCH = 2'd1;
    localparam logic [1:0]  ST_DRAW  = 2'd2;

    // Plane 1 lives in the upper half-word, plane 0 in the lower; bit 15/31 is the leftmost pixel
    function automatic logic [1:0] obj_pix(input logic [31:0] data, input logic [3:0] n,
                                           input logic hflip);
        logic [3:0] k;
        k = hflip ? 4'd15 - n : n;
        return {data[5'd31 - {1'b0, k}], data[5'd15 - {1'b0, k}]};
    endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Two-port RAM on one clock: port 0 is write-only, port 1 is read/write with a
// registered read.
module jtframe_dual_ram #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic [DW-1:0] data0,
    input  logic [AW-1:0] addr0,
    input  logic          we0,
    input  logic [DW-1:0] data1,
    input  logic [AW-1:0] addr1,
    input  logic          we1,
    output logic [DW-1:0] q1
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we0) mem[addr0] <= data0;
        if (we1) mem[addr1] <= data1;
        q1 <= mem[addr1];
    end

endmodule

// File: rtl/jtframe_prom.sv
// Small registered-read PROM with a download write port; a same-cycle
// read/write of one entry returns the old contents.
module jtframe_prom #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          cen,
    input  logic [DW-1:0] data,
    input  logic [AW-1:0] rd_addr,
    input  logic [AW-1:0] wr_addr,
    input  logic          we,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (cen) q <= mem[rd_addr];
        if (we)  mem[wr_addr] <= data;
    end

endmodule

// File: rtl/jtpinpon_objbuf.sv
// Double line buffer: draws land in the back bank, the front bank is read out on
// pxl_cen and each read column is erased on the following pxl_cen.
module jtpinpon_objbuf (
    input  logic       clk,
    input  logic       rst,
    input  logic       bank,
    input  logic [7:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       wr_en,
    input  logic       rd_cen,
    input  logic       rd_en,
    input  logic [7:0] rd_addr,
    output logic [3:0] pxl
);

    logic [7:0] er_addr;
    logic       er_bank, er_pend;
    logic [8:0] b_addr;
    logic       b_we;
    logic [3:0] q1;

    // The read port samples rd_addr between pxl_cen pulses; on the pulse itself it
    // is borrowed for the erase, so pxl_cen must not fire on consecutive clocks
    always_comb begin
        b_addr = {bank, rd_addr};
        b_we   = 1'b0;
        if (rd_cen && er_pend) begin
            b_addr = {er_bank, er_addr};
            b_we   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pxl     <= '0;
            er_pend <= 1'b0;
            er_addr <= '0;
            er_bank <= 1'b0;
        end else if (rd_cen) begin
            pxl     <= rd_en ? q1 : '0;
            er_pend <= rd_en;
            er_addr <= rd_addr;
            er_bank <= bank;
        end
    end

    jtframe_dual_ram #(.DW(4), .AW(9)) u_ram (
        .clk   (clk),
        .data0 (wr_data),
        .addr0 ({~bank, wr_addr}),
        .we0   (wr_en),
        .data1 (4'd0),
        .addr1 (b_addr),
        .we1   (b_we),
        .q1    (q1)
    );

endmodule

// File: rtl/jtpinpon_objline.sv
// Object draw engine: fetches one 16-pixel sprite row per request, colours it
// through the PROM and paints it into the back half of the line buffer.
module jtpinpon_objline
    import jtpinpon_objline_pkg::*;
#(
    parameter logic [7:0] HOFFSET = 8'd6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pxl_cen,
    input  logic        cen2,
    input  logic        LHBL,
    input  logic        hinit_x,
    input  logic [8:0]  hdump,
    input  logic        draw,
    output logic        busy,
    input  logic [7:0]  code,
    input  logic [7:0]  xpos,
    input  logic [4:0]  pal,
    input  logic        hflip,
    input  logic        vflip,
    input  logic [3:0]  ysub,
    input  logic [3:0]  prog_data,
    input  logic [7:0]  prog_addr,
    input  logic        prog_en,
    output logic        rom_cs,
    output logic [11:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        rom_ok,
    output logic [3:0]  pxl
);

    logic [1:0]  st;
    logic        bank, hinit_l, hinit_rise, fetch_wait;
    logic [7:0]  l_xpos, wr_col, ra;
    logic [4:0]  l_pal;
    logic        l_hflip;
    logic [3:0]  n;
    logic [31:0] pix_data;
    logic        wr_pend, wr_en;
    logic [7:0]  prom_addr;
    logic [3:0]  prom_q;
    logic        unused_hdump;

    assign unused_hdump = hdump[8];
    assign hinit_rise   = hinit_x & ~hinit_l;
    assign ra           = hdump[7:0] + HOFFSET;
    assign prom_addr    = {1'b0, l_pal, obj_pix(pix_data, n, l_hflip)};
    // The colour for pixel n arrives one clk after its cen2; a line swap kills it
    assign wr_en        = wr_pend & (prom_q != TRANSP) & ~hinit_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= ST_IDLE;
            bank       <= 1'b0;
            hinit_l    <= 1'b0;
            fetch_wait <= 1'b0;
            busy       <= 1'b0;
            rom_cs     <= 1'b0;
            rom_addr   <= '0;
            l_xpos     <= '0;
            l_pal      <= '0;
            l_hflip    <= 1'b0;
            n          <= '0;
            pix_data   <= '0;
            wr_pend    <= 1'b0;
            wr_col     <= '0;
        end else begin
            hinit_l <= hinit_x;
            wr_pend <= 1'b0;
            if (hinit_rise) begin
                bank   <= ~bank;
                st     <= ST_IDLE;
                busy   <= 1'b0;
                rom_cs <= 1'b0;
            end else begin
                case (st)
                    ST_IDLE: begin
                        if (cen2 && draw && !hinit_x) begin
                            l_xpos     <= xpos;
                            l_pal      <= pal;
                            l_hflip    <= hflip;
                            rom_addr   <= {code, ysub ^ {4{vflip}}};
                            rom_cs     <= 1'b1;
                            busy       <= 1'b1;
                            fetch_wait <= 1'b1;
                            st         <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        if (fetch_wait) begin
                            fetch_wait <= 1'b0;
                        end else if (rom_ok) begin
                            pix_data <= rom_data;
                            rom_cs   <= 1'b0;
                            n        <= '0;
                            st       <= ST_DRAW;
                        end
                    end
                    ST_DRAW: begin
                        if (cen2) begin
                            wr_pend <= 1'b1;
                            wr_col  <= l_xpos + {4'd0, n};
                            n       <= n + 4'd1;
                            if (n == 4'd15) begin
                                busy <= 1'b0;
                                st   <= ST_IDLE;
                            end
                        end
                    end
                    default: st <= ST_IDLE;
                endcase
            end
        end
    end

    jtframe_prom #(.DW(4), .AW(8)) u_prom (
        .clk     (clk),
        .cen     (1'b1),
        .data    (prog_data),
        .rd_addr (prom_addr),
        .wr_addr (prog_addr),
        .we      (prog_en),
        .q       (prom_q)
    );

    jtpinpon_objbuf u_buf (
        .clk     (clk),
        .rst     (rst),
        .bank    (bank),
        .wr_addr (wr_col),
        .wr_data (prom_q),
        .wr_en   (wr_en),
        .rd_cen  (pxl_cen),
        .rd_en   (LHBL),
        .rd_addr (ra),
        .pxl     (pxl)
    );

endmodule

// File: doc/jtpinpon_objline.md
Name: jtpinpon_objline

Overview:
- Draw-side responder for the object table scanner.
- Accepts one object per `draw` pulse and holds `busy` while it works.
- For each object it fetches one 16-pixel sprite row from SDRAM and maps each pixel through the 4-bit colour PROM.
- Non-transparent pixels go into the back half of a double line buffer, while the front half is streamed out as `pxl` and erased behind the beam.

Parameters:
- HOFFSET, 8'd6: added to hdump[7:0] to form the line-buffer read address.

Ports:
- clk        in   1   48 MHz system clock
- rst        in   1   asynchronous, active-high reset
- pxl_cen    in   1   pixel clock enable
- cen2       in   1   clk/2 enable; sets the scanner handshake and draw rate
- LHBL       in   1   horizontal blank, active low
- hinit_x    in   1   line start, one cen2 period wide; swaps the buffer halves
- hdump      in   9   horizontal dump counter
- draw       in   1   object request, sampled on cen2
- busy       out  1   object being processed
- code       in   8   tile code
- xpos       in   8   left pixel column
- pal        in   5   palette
- hflip      in   1   horizontal flip
- vflip      in   1   vertical flip
- ysub       in   4   row within the object
- prog_data  in   4   PROM download data
- prog_addr  in   8   PROM download address
- prog_en    in   1   PROM download write enable
- rom_cs     out  1   SDRAM request
- rom_addr   out  12  SDRAM word address
- rom_data   in   32  SDRAM data
- rom_ok     in   1   SDRAM data valid
- pxl        out  4   object colour; 0 = transparent

Behaviour:
- Reset: busy=0, rom_cs=0, rom_addr=0, pxl=0, FSM=IDLE, bank=0.
- Line buffer contents are not reset.

Draw FSM (advances on cen2 except FETCH):
- IDLE:
  - When draw=1 and cen2: latch code/xpos/pal/flips/ysub.
  - Set rom_addr={code, ysub^{4{vflip}}} and rom_cs=1.
  - busy=1 from the next clk, so it is guaranteed high by the following cen2.
  - Go to FETCH.
- FETCH:
  - Evaluated on every clk.
  - rom_ok is ignored on the first clk after the address is set.
  - Thereafter, rom_ok=1: latch rom_data, set rom_cs=0, set pixel counter n=0, go to DRAW.
- DRAW, one pixel per cen2:
  - Pixel index k = hflip ? 15-n : n.
  - Pixel value pix = {rom_data[31-k], rom_data[15-k]}.
  - Colour c = PROM[{1'b0, pal, pix}].
  - If c != 0, write c at back[(xpos+n) mod 256] (8-bit wrap).
  - After n=15: busy=0, go to IDLE.
- draw is ignored while busy=1.
- Overwrite order: the later object wins.

Line start:
- On hinit_x (first clk) the bank toggles.
- Any object in FETCH or DRAW is aborted: rom_cs=0, busy=0, FSM=IDLE.
- hinit_x has priority over a coincident draw; that draw is dropped.

Readout, on pxl_cen:
- Read address ra = hdump[7:0] + HOFFSET (mod 256).
- pxl = LHBL ? front[ra] : 0, registered, 1 pxl_cen latency.
- front[ra] is cleared to 0 on the pxl_cen after it is read, and only when LHBL=1.

PROM:
- Written when prog_en=1: PROM[prog_addr] <= prog_data.
- A read and write to the same entry in one cycle returns the old data.

Back-bank conflicts:
- Draw writes and readout erases touch different banks, so they never collide.

Reset mid-operation:
- Returns the block to IDLE immediately.
- A pending SDRAM request is dropped, with no wait for rom_ok.

Decomposition:
- Shared package constants:
  - OBJ_W=16, BPP=2, transparent colour 0.
  - FSM state encoding: IDLE, FETCH, DRAW.
- Sub-module jtpinpon_objbuf: 2×256×4 double line buffer.
  - Draw write port, readout read-then-erase port, bank select.
  - Built on jtframe_dual_ram.
- PROM: a 256×4 jtframe_prom instance inside this block.

Test Plan:
- Single object, code=8'h12, ysub=3, vflip=0, xpos=40, rom_data=32'hFFFF_0000, PROM[{0,pal=2,2'b10}]=4'h9 -> rom_addr=12'h123; after swap, pxl=9 at ra=40..55 and 0 elsewhere.
- Same object with hflip=1, vflip=1, rom_data=32'h8000_0001 -> rom_addr=12'h12C; pixel 0 has pix=2'b01 and pixel 15 has pix=2'b10.
- xpos=250 -> columns 250..255 and 0..9 written (wrap-around).
- Two overlapping objects at xpos 10 and 18 with colours 5 then 7 -> columns 18..25 read 7.
- Transparency: PROM[...pix]=0 -> column keeps the earlier value; a second line read returns 0 (erase verified).
- rom_ok held low for 20 clk, then hinit_x -> busy and rom_cs fall, and a later draw is accepted normally. Also: draw pulsed while busy -> ignored, rom_addr unchanged.
